// File: rtl/ir_status_rx_pkg.sv
// Shared constants and state types for the obstacle-status UART link.
// Used by both the receiver here and the sensor-board transmitter top.
package ir_link_pkg;

  localparam int DEFAULT_CLK_FREQ = 12000000;
  localparam int DEFAULT_BAUD     = 9600;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } byteState_t;

  typedef enum logic {
    WAIT_CHAR,
    WAIT_NL
  } lineState_t;

endpackage

// File: rtl/ir_status_rx_if.sv
// Serial input plus decoded-status outputs of the obstacle-status receiver.
// The receiver is the slave side; the consumer (or a bench) is the master.
interface ir_status_rx_if;

  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       line_valid;
  logic       parse_err;
  logic       obstacle;
  logic       status_valid;
  logic       timeout;

  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_err, line_valid, parse_err,
           obstacle, status_valid, timeout
  );

  modport master (
    output rx,
    input  rx_data, rx_valid, frame_err, line_valid, parse_err,
           obstacle, status_valid, timeout
  );

endinterface

// File: rtl/ir_status_rx_uart.sv
// 8N1 byte receiver: 2-FF synchronizer, start-edge detect, mid-bit sampling.
// Emits each good byte with a one-cycle valid pulse, or a framing-error pulse.
module uart_rx_8n1
  import ir_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLK_FREQ / DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rxData_o,
  output logic       rxValid_o,
  output logic       frameErr_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  logic          rxSync1_q, rxSync2_q, rxPrev_q;
  byteState_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rxData_q, rxData_d;
  logic          rxValid_q, rxValid_d;
  logic          frameErr_q, frameErr_d;
  logic          fallEdge;

  // Synchronizer and edge history reset high so an idle line is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxSync1_q  <= 1'b1;
      rxSync2_q  <= 1'b1;
      rxPrev_q   <= 1'b1;
      state_q    <= IDLE;
      timer_q    <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      rxSync1_q  <= rx_i;
      rxSync2_q  <= rxSync1_q;
      rxPrev_q   <= rxSync2_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign fallEdge = rxPrev_q & ~rxSync2_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    frameErr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fallEdge) begin
          state_d  = START;
          timer_d  = '0;
          bitCnt_d = '0;
        end
      end
      START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          state_d = rxSync2_q ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d  = '0;
          shift_d  = {rxSync2_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rxSync2_q) begin
            rxData_d  = shift_q;
            rxValid_d = 1'b1;
            state_d   = IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = RECOVER;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RECOVER: begin
        if (rxSync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rxData_o   = rxData_q;
  assign rxValid_o  = rxValid_q;
  assign frameErr_o = frameErr_q;

endmodule

// File: rtl/ir_status_rx.sv
// Obstacle-status receiver: byte receiver plus "0"/"1" + LF line parser.
// Optional staleness timeout is built when IR_STATUS_RX_TIMEOUT_EN is defined.
module ir_status_rx
  import ir_link_pkg::*;
#(
  parameter int CLK_FREQ       = DEFAULT_CLK_FREQ,
  parameter int BAUD           = DEFAULT_BAUD,
  parameter int TIMEOUT_CYCLES = 24000000
) (
  input  logic          clk,
  input  logic          rst,
  ir_status_rx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  logic [7:0] rxData;
  logic       rxValid;
  logic       frameErr;

  lineState_t state_q, state_d;
  logic       pending_q, pending_d;
  logic       obstacle_q, obstacle_d;
  logic       statusValid_q, statusValid_d;
  logic       lineValid_q, lineValid_d;
  logic       parseErr_q, parseErr_d;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uRx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (bus.rx),
    .rxData_o  (rxData),
    .rxValid_o (rxValid),
    .frameErr_o(frameErr)
  );

`ifdef IR_STATUS_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic            timeout_q, timeout_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_CHAR;
      pending_q     <= 1'b0;
      obstacle_q    <= 1'b0;
      statusValid_q <= 1'b0;
      lineValid_q   <= 1'b0;
      parseErr_q    <= 1'b0;
`ifdef IR_STATUS_RX_TIMEOUT_EN
      toCnt_q       <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      obstacle_q    <= obstacle_d;
      statusValid_q <= statusValid_d;
      lineValid_q   <= lineValid_d;
      parseErr_q    <= parseErr_d;
`ifdef IR_STATUS_RX_TIMEOUT_EN
      toCnt_q       <= toCnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  // A framing error drops any half-received line silently.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    obstacle_d    = obstacle_q;
    statusValid_d = statusValid_q;
    lineValid_d   = 1'b0;
    parseErr_d    = 1'b0;

    if (frameErr) begin
      state_d   = WAIT_CHAR;
      pending_d = 1'b0;
    end else if (rxValid) begin
      unique case (state_q)
        WAIT_CHAR: begin
          if (rxData == ASCII_0 || rxData == ASCII_1) begin
            pending_d = rxData[0];
            state_d   = WAIT_NL;
          end else if (rxData != ASCII_CR) begin
            parseErr_d = 1'b1;
          end
        end
        WAIT_NL: begin
          if (rxData == ASCII_LF) begin
            obstacle_d    = pending_q;
            statusValid_d = 1'b1;
            lineValid_d   = 1'b1;
            state_d       = WAIT_CHAR;
          end else if (rxData != ASCII_CR) begin
            parseErr_d = 1'b1;
            pending_d  = 1'b0;
            state_d    = WAIT_CHAR;
          end
        end
        default: state_d = WAIT_CHAR;
      endcase
    end

`ifdef IR_STATUS_RX_TIMEOUT_EN
    // A new good line takes priority over an expiry landing on the same cycle.
    timeout_d = !lineValid_d && statusValid_q && (toCnt_q == TO_LIMIT - 1'b1);
    if (timeout_d) statusValid_d = 1'b0;
    if (lineValid_d)             toCnt_d = '0;
    else if (toCnt_q == TO_LIMIT) toCnt_d = toCnt_q;
    else                          toCnt_d = toCnt_q + 1'b1;
`endif
  end

  assign bus.rx_data      = rxData;
  assign bus.rx_valid     = rxValid;
  assign bus.frame_err    = frameErr;
  assign bus.line_valid   = lineValid_q;
  assign bus.parse_err    = parseErr_q;
  assign bus.obstacle     = obstacle_q;
  assign bus.status_valid = statusValid_q;

`ifdef IR_STATUS_RX_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ir_status_rx.sv
// Directed bench for ir_status_rx: good lines, CR handling, framing error,
// start glitch, malformed line, mid-byte reset and (if enabled) timeout.
module tb_ir_status_rx;
  import ir_link_pkg::*;

  localparam int CLK_FREQ = 12000000;
  localparam int BAUD     = 25000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int TIMEOUT  = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ir_status_rx_if bus ();

  ir_status_rx #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUD          (BAUD),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errorCount = 0;
  int checkCount = 0;

  int cycleNum = 0;
  int nRxValid = 0, nFrameErr = 0, nLineValid = 0, nParseErr = 0, nTimeout = 0;
  int lastLfCycle = -1, lastLineCycle = -1, lastTimeoutCycle = -1;
  int widePulse = 0;
  logic [4:0] prevPulses = '0;
  logic [7:0] byteLog[$];

  int bRx, bFe, bLv, bPe, bLog;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Event log sampled mid-cycle; also catches any pulse lasting two cycles.
  always @(negedge clk) begin
    logic [4:0] pulses;
    pulses = {bus.rx_valid, bus.frame_err, bus.line_valid, bus.parse_err, bus.timeout};
    if (!rst) begin
      if (bus.rx_valid) begin
        nRxValid++;
        byteLog.push_back(bus.rx_data);
        if (bus.rx_data == ASCII_LF) lastLfCycle = cycleNum;
      end
      if (bus.frame_err)  nFrameErr++;
      if (bus.line_valid) begin nLineValid++; lastLineCycle = cycleNum; end
      if (bus.parse_err)  nParseErr++;
      if (bus.timeout)    begin nTimeout++; lastTimeoutCycle = cycleNum; end
      if (|(pulses & prevPulses)) widePulse++;
    end
    prevPulses = pulses;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stopBit;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    if (!stopBit) repeat (CPB) @(negedge clk);
  endtask

  task automatic sendLine(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic snapshot();
    bRx  = nRxValid;
    bFe  = nFrameErr;
    bLv  = nLineValid;
    bPe  = nParseErr;
    bLog = byteLog.size();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rx_data"},      32'(bus.rx_data),      32'h00);
    checkOutput({tag, "_rx_valid"},     32'(bus.rx_valid),     32'h0);
    checkOutput({tag, "_frame_err"},    32'(bus.frame_err),    32'h0);
    checkOutput({tag, "_line_valid"},   32'(bus.line_valid),   32'h0);
    checkOutput({tag, "_parse_err"},    32'(bus.parse_err),    32'h0);
    checkOutput({tag, "_timeout"},      32'(bus.timeout),      32'h0);
    checkOutput({tag, "_obstacle"},     32'(bus.obstacle),     32'h0);
    checkOutput({tag, "_status_valid"}, 32'(bus.status_valid), 32'h0);
  endtask

  initial begin
    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (5) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // "1\n": two bytes, one good line, obstacle set
    snapshot();
    sendLine("1\n");
    checkOutput("l1_rx_count", 32'(nRxValid - bRx), 32'd2);
    if (byteLog.size() >= bLog + 2) begin
      checkOutput("l1_byte0", 32'(byteLog[bLog]),     32'h31);
      checkOutput("l1_byte1", 32'(byteLog[bLog + 1]), 32'h0A);
    end
    checkOutput("l1_line_count",  32'(nLineValid - bLv),          32'd1);
    checkOutput("l1_line_latency", 32'(lastLineCycle - lastLfCycle), 32'd1);
    checkOutput("l1_parse_count", 32'(nParseErr - bPe),           32'd0);
    checkOutput("l1_obstacle",    32'(bus.obstacle),              32'h1);
    checkOutput("l1_status",      32'(bus.status_valid),          32'h1);
    checkOutput("l1_rx_data_hold", 32'(bus.rx_data),              32'h0A);

    // "0\r\n": CR is ignored between digit and LF
    snapshot();
    sendLine("0\r\n");
    checkOutput("l0_rx_count",    32'(nRxValid - bRx),  32'd3);
    checkOutput("l0_line_count",  32'(nLineValid - bLv), 32'd1);
    checkOutput("l0_parse_count", 32'(nParseErr - bPe), 32'd0);
    checkOutput("l0_obstacle",    32'(bus.obstacle),    32'h0);
    checkOutput("l0_status",      32'(bus.status_valid), 32'h1);

    // Bad stop bit, then a good "1\n"
    snapshot();
    applyStimulus(8'h55, 1'b0);
    checkOutput("fe_frame_count", 32'(nFrameErr - bFe), 32'd1);
    checkOutput("fe_rx_count",    32'(nRxValid - bRx),  32'd0);
    sendLine("1\n");
    checkOutput("fe_rx_after",    32'(nRxValid - bRx),   32'd2);
    checkOutput("fe_line_count",  32'(nLineValid - bLv), 32'd1);
    checkOutput("fe_obstacle",    32'(bus.obstacle),     32'h1);

    // "11\n": second digit and orphan LF are both malformed
    snapshot();
    sendLine("11\n");
    checkOutput("dd_rx_count",    32'(nRxValid - bRx),   32'd3);
    checkOutput("dd_parse_count", 32'(nParseErr - bPe),  32'd2);
    checkOutput("dd_line_count",  32'(nLineValid - bLv), 32'd0);
    checkOutput("dd_obstacle",    32'(bus.obstacle),     32'h1);

    // 200-cycle low glitch is rejected at the start-bit sample
    snapshot();
    bus.rx = 1'b0;
    repeat (200) @(negedge clk);
    bus.rx = 1'b1;
    repeat (CPB) @(negedge clk);
    checkOutput("gl_rx_count",    32'(nRxValid - bRx),  32'd0);
    checkOutput("gl_frame_count", 32'(nFrameErr - bFe), 32'd0);
    sendLine("0\n");
    checkOutput("gl_line_count",  32'(nLineValid - bLv), 32'd1);
    checkOutput("gl_obstacle",    32'(bus.obstacle),     32'h0);
    sendLine("1\n");
    checkOutput("gl_obstacle2",   32'(bus.obstacle),     32'h1);

    // Reset in the middle of a byte aborts it without pulses
    snapshot();
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkResetState("mid_rst");
    rst = 1'b0;
    repeat (11 * CPB) @(negedge clk);
    checkOutput("mid_rst_rx_count",    32'(nRxValid - bRx),  32'd0);
    checkOutput("mid_rst_frame_count", 32'(nFrameErr - bFe), 32'd0);
    checkOutput("mid_rst_status",      32'(bus.status_valid), 32'h0);

`ifdef IR_STATUS_RX_TIMEOUT_EN
    begin
      int waited;
      sendLine("1\n");
      checkOutput("to_status_before", 32'(bus.status_valid), 32'h1);
      waited = 0;
      while (lastTimeoutCycle < 0 && waited < TIMEOUT + 1000) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("to_latency", 32'(lastTimeoutCycle - lastLineCycle), 32'(TIMEOUT));
      repeat (3) @(negedge clk);
      checkOutput("to_status_after", 32'(bus.status_valid), 32'h0);
      checkOutput("to_obstacle",     32'(bus.obstacle),     32'h1);
      repeat (200) @(negedge clk);
      checkOutput("to_count",        32'(nTimeout),         32'd1);
    end
`else
    checkOutput("to_never", 32'(nTimeout), 32'd0);
`endif

    checkOutput("pulse_width", 32'(widePulse), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
